// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and FSM encoding for the I2S DAC serializer
package audio_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LEFT  = 2'd1;
  localparam state_t ST_RIGHT = 2'd2;

  localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == UNDERRUN_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - synchronous stereo-pair FIFO with level, full and empty
module audio_sample_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  // A full FIFO refuses the write even if a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/i2s_dac_serializer.sv
// rtl/i2s_dac_serializer.sv - left-justified stereo serializer driven by codec-mastered BCLK/LRCK
module i2s_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  input  logic [DATA_WIDTH-1:0]         left_channel_audio_in,
  input  logic [DATA_WIDTH-1:0]         right_channel_audio_in,
  input  logic                          write_audio_out,
  output logic                          audio_out_allowed,
  output logic                          AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    underrun_count
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] DONE_CNT = CW'(DATA_WIDTH);

  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
  logic                   bclk_hist_q, bclk_hist_d;
  logic                   lrck_hist_q, lrck_hist_d;
  logic [SYNC_STAGES:0]   prime_q, prime_d;
  logic                   edges_en, bclk_now, lrck_now;
  logic                   bclk_fall, lrck_rise, lrck_fall;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  right_hold_q, right_hold_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]             underrun_q, underrun_d;
  logic                   dacdat_q, dacdat_d;

  logic                       fifo_pop, fifo_full, fifo_empty;
  logic [2*DATA_WIDTH-1:0]    fifo_rd_data;

  audio_sample_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst     (reset),
    .push    (write_audio_out),
    .pop     (fifo_pop),
    .wr_data ({left_channel_audio_in, right_channel_audio_in}),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign audio_out_allowed = ~fifo_full;
  assign AUD_DACDAT        = dacdat_q;
  assign underrun_count    = underrun_q;

  // Edges stay masked until the history flop holds a real pin sample, so the
  // first frame after reset can never start from a fake LRCK edge.
  assign edges_en  = prime_q[SYNC_STAGES];
  assign bclk_now  = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_now  = lrck_sync_q[SYNC_STAGES-1];
  assign bclk_fall = edges_en & bclk_hist_q & ~bclk_now;
  assign lrck_rise = edges_en & ~lrck_hist_q & lrck_now;
  assign lrck_fall = edges_en & lrck_hist_q & ~lrck_now;

  always_comb begin
    bclk_sync_d = SYNC_STAGES'({bclk_sync_q, AUD_BCLK});
    lrck_sync_d = SYNC_STAGES'({lrck_sync_q, AUD_DACLRCK});
    bclk_hist_d = bclk_now;
    lrck_hist_d = lrck_now;
    prime_d     = (SYNC_STAGES+1)'({prime_q, 1'b1});
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    right_hold_d = right_hold_q;
    bit_cnt_d    = bit_cnt_q;
    underrun_d   = underrun_q;
    fifo_pop     = 1'b0;
    // LRCK events take priority over a coincident BCLK fall so the MSB is held.
    if (lrck_rise) begin
      state_d   = ST_LEFT;
      bit_cnt_d = '0;
      if (!fifo_empty) begin
        fifo_pop     = 1'b1;
        shift_d      = fifo_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
        right_hold_d = fifo_rd_data[DATA_WIDTH-1:0];
      end else begin
        shift_d      = '0;
        right_hold_d = '0;
        underrun_d   = sat_inc(underrun_q);
      end
    end else if (lrck_fall) begin
      if (state_q == ST_LEFT) begin
        state_d   = ST_RIGHT;
        shift_d   = right_hold_q;
        bit_cnt_d = '0;
      end
    end else if (bclk_fall && (state_q != ST_IDLE)) begin
      if (bit_cnt_q < LAST_BIT) begin
        shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CW'(1);
      end else if (bit_cnt_q == LAST_BIT) begin
        shift_d   = '0;
        bit_cnt_d = DONE_CNT;
      end
    end
    dacdat_d = ((state_q != ST_IDLE) && (bit_cnt_q < DONE_CNT)) ? shift_q[DATA_WIDTH-1] : 1'b0;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bclk_sync_q  <= '0;
      lrck_sync_q  <= '0;
      bclk_hist_q  <= 1'b0;
      lrck_hist_q  <= 1'b0;
      prime_q      <= '0;
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      right_hold_q <= '0;
      bit_cnt_q    <= '0;
      underrun_q   <= '0;
      dacdat_q     <= 1'b0;
    end else begin
      bclk_sync_q  <= bclk_sync_d;
      lrck_sync_q  <= lrck_sync_d;
      bclk_hist_q  <= bclk_hist_d;
      lrck_hist_q  <= lrck_hist_d;
      prime_q      <= prime_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      right_hold_q <= right_hold_d;
      bit_cnt_q    <= bit_cnt_d;
      underrun_q   <= underrun_d;
      dacdat_q     <= dacdat_d;
    end
  end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// tb/tb_i2s_dac_serializer.sv - self-checking bench for i2s_dac_serializer
module tb_i2s_dac_serializer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          AUD_BCLK = 1'b1;
  logic          AUD_DACLRCK = 1'b0;
  logic [DW-1:0] left_in = '0;
  logic [DW-1:0] right_in = '0;
  logic          write_audio_out = 1'b0;
  logic          audio_out_allowed;
  logic          AUD_DACDAT;
  logic [2:0]    fifo_level;
  logic [7:0]    underrun_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mq[$];
  int          m_under = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  i2s_dac_serializer #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SS)
  ) dut (
    .CLOCK_50               (CLOCK_50),
    .reset                  (reset),
    .AUD_BCLK               (AUD_BCLK),
    .AUD_DACLRCK            (AUD_DACLRCK),
    .left_channel_audio_in  (left_in),
    .right_channel_audio_in (right_in),
    .write_audio_out        (write_audio_out),
    .audio_out_allowed      (audio_out_allowed),
    .AUD_DACDAT             (AUD_DACDAT),
    .fifo_level             (fifo_level),
    .underrun_count         (underrun_count)
  );

  task automatic clk_n(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic apply_reset(input logic lr);
    reset = 1'b1;
    AUD_BCLK = 1'b1;
    AUD_DACLRCK = lr;
    write_audio_out = 1'b0;
    mq.delete();
    m_under = 0;
    clk_n(3);
    reset = 1'b0;
    clk_n(SS + 3);
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic accept;
    accept = (mq.size() < DEPTH);
    left_in = l;
    right_in = r;
    write_audio_out = 1'b1;
    clk_n(1);
    write_audio_out = 1'b0;
    if (accept) mq.push_back({l, r});
  endtask

  // Codec-side bit clock: 8 system clocks low, 8 high; LRCK changes with the fall.
  task automatic bclk_tick(input logic lr, inout logic [63:0] bits);
    AUD_BCLK = 1'b0;
    AUD_DACLRCK = lr;
    clk_n(8);
    AUD_BCLK = 1'b1;
    bits = {bits[62:0], AUD_DACDAT};
    clk_n(8);
  endtask

  task automatic run_half(input logic lr, input int nb, output logic [63:0] bits);
    bits = '0;
    for (int i = 0; i < nb; i++) bclk_tick(lr, bits);
  endtask

  task automatic run_frame(input int nb, output logic [63:0] lb, output logic [63:0] rb);
    run_half(1'b1, nb, lb);
    run_half(1'b0, nb, rb);
  endtask

  task automatic quick_frame();
    AUD_DACLRCK = 1'b1;
    clk_n(6);
    AUD_DACLRCK = 1'b0;
    clk_n(6);
  endtask

  // Reference: one frame start pops a pair (or counts an underrun); each half
  // carries the word MSB-first followed by zeros for any extra bit clocks.
  task automatic model_frame(input int nb, output logic [63:0] el, output logic [63:0] er);
    logic [DW-1:0] l, r;
    l = '0;
    r = '0;
    el = '0;
    er = '0;
    if (mq.size() > 0) {l, r} = mq.pop_front();
    else if (m_under < 255) m_under++;
    for (int i = 0; i < nb; i++) begin
      el = {el[62:0], (i < DW) ? l[DW-1-i] : 1'b0};
      er = {er[62:0], (i < DW) ? r[DW-1-i] : 1'b0};
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clk_n(2);
    n_cmp++; if (AUD_DACDAT !== 1'b0) begin n_err++; $display("FAIL rst_dacdat: got %b want 0", AUD_DACDAT); end
    n_cmp++; if (audio_out_allowed !== 1'b1) begin n_err++; $display("FAIL rst_allowed: got %b want 1", audio_out_allowed); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    n_cmp++; if (underrun_count !== 8'd0) begin n_err++; $display("FAIL rst_underrun: got %0d want 0", underrun_count); end
    apply_reset(1'b0);
    n_cmp++; if (AUD_DACDAT !== 1'b0) begin n_err++; $display("FAIL post_rst_dacdat: got %b want 0", AUD_DACDAT); end
  endtask

  task automatic test_basic_frame();
    logic [63:0] lb, rb, el, er;
    apply_reset(1'b0);
    push_pair(32'hA5A5_0001, 32'h5A5A_8000);
    n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL basic_level_pre: got %0d want 1", fifo_level); end
    run_frame(32, lb, rb);
    model_frame(32, el, er);
    n_cmp++; if (lb !== el) begin n_err++; $display("FAIL basic_left: got %h want %h", lb, el); end
    n_cmp++; if (rb !== er) begin n_err++; $display("FAIL basic_right: got %h want %h", rb, er); end
    n_cmp++; if (fifo_level !== 3'(mq.size())) begin n_err++; $display("FAIL basic_level_post: got %0d want %0d", fifo_level, mq.size()); end
    n_cmp++; if (underrun_count !== 8'(m_under)) begin n_err++; $display("FAIL basic_underrun: got %0d want %0d", underrun_count, m_under); end
  endtask

  task automatic test_full_fifo();
    logic [63:0] lb, rb, el, er;
    logic        exp_allowed;
    apply_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      exp_allowed = (mq.size() < DEPTH);
      n_cmp++; if (audio_out_allowed !== exp_allowed) begin n_err++; $display("FAIL full_allowed_%0d: got %b want %b", i, audio_out_allowed, exp_allowed); end
      push_pair($urandom, $urandom);
      n_cmp++; if (fifo_level !== 3'(mq.size())) begin n_err++; $display("FAIL full_level_%0d: got %0d want %0d", i, fifo_level, mq.size()); end
    end
    n_cmp++; if (audio_out_allowed !== 1'b0) begin n_err++; $display("FAIL full_allowed_end: got %b want 0", audio_out_allowed); end
    for (int f = 0; f < 4; f++) begin
      run_frame(32, lb, rb);
      model_frame(32, el, er);
      n_cmp++; if (lb !== el) begin n_err++; $display("FAIL full_left_%0d: got %h want %h", f, lb, el); end
      n_cmp++; if (rb !== er) begin n_err++; $display("FAIL full_right_%0d: got %h want %h", f, rb, er); end
    end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL full_drained: got %0d want 0", fifo_level); end
  endtask

  task automatic test_underrun();
    logic [63:0] lb, rb, el, er;
    apply_reset(1'b0);
    for (int f = 0; f < 3; f++) begin
      run_frame(32, lb, rb);
      model_frame(32, el, er);
      n_cmp++; if ((lb | rb) !== (el | er)) begin n_err++; $display("FAIL under_data_%0d: got %h/%h want %h/%h", f, lb, rb, el, er); end
    end
    n_cmp++; if (underrun_count !== 8'(m_under)) begin n_err++; $display("FAIL under_count3: got %0d want %0d", underrun_count, m_under); end
    for (int f = 0; f < 297; f++) begin
      quick_frame();
      model_frame(0, el, er);
    end
    n_cmp++; if (underrun_count !== 8'(m_under)) begin n_err++; $display("FAIL under_saturate: got %0d want %0d", underrun_count, m_under); end
  endtask

  task automatic test_simultaneous();
    logic [63:0] lb, rb, el, er;
    logic [DW-1:0] xl, xr;
    apply_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) push_pair($urandom, $urandom);
    n_cmp++; if (audio_out_allowed !== 1'b0) begin n_err++; $display("FAIL simul_allowed_full: got %b want 0", audio_out_allowed); end
    xl = $urandom;
    xr = $urandom;
    left_in = xl;
    right_in = xr;
    write_audio_out = 1'b1;
    fork
      run_frame(32, lb, rb);
      begin
        clk_n(8);
        write_audio_out = 1'b0;
      end
    join
    model_frame(32, el, er);
    mq.push_back({xl, xr});
    n_cmp++; if (lb !== el) begin n_err++; $display("FAIL simul_left: got %h want %h", lb, el); end
    n_cmp++; if (fifo_level !== 3'(mq.size())) begin n_err++; $display("FAIL simul_level: got %0d want %0d", fifo_level, mq.size()); end
    for (int f = 0; f < 4; f++) begin
      run_frame(32, lb, rb);
      model_frame(32, el, er);
      n_cmp++; if ({lb, rb} !== {el, er}) begin n_err++; $display("FAIL simul_frame_%0d: got %h/%h want %h/%h", f, lb, rb, el, er); end
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] lb, rb, el, er;
    apply_reset(1'b0);
    push_pair($urandom, $urandom);
    push_pair($urandom, $urandom);
    run_half(1'b1, 10, lb);
    model_frame(10, el, er);
    n_cmp++; if (lb !== el) begin n_err++; $display("FAIL midrst_partial: got %h want %h", lb, el); end
    reset = 1'b1;
    #1;
    n_cmp++; if (AUD_DACDAT !== 1'b0) begin n_err++; $display("FAIL midrst_dacdat: got %b want 0", AUD_DACDAT); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL midrst_level: got %0d want 0", fifo_level); end
    mq.delete();
    m_under = 0;
    clk_n(2);
    reset = 1'b0;
    clk_n(SS + 3);
    push_pair($urandom, $urandom);
    run_half(1'b1, 22, lb);
    run_half(1'b0, 32, rb);
    n_cmp++; if ({lb, rb} !== 128'd0) begin n_err++; $display("FAIL midrst_idle_out: got %h/%h want 0", lb, rb); end
    n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL midrst_no_pop: got %0d want 1", fifo_level); end
    run_frame(32, lb, rb);
    model_frame(32, el, er);
    n_cmp++; if ({lb, rb} !== {el, er}) begin n_err++; $display("FAIL midrst_resume: got %h/%h want %h/%h", lb, rb, el, er); end
  endtask

  task automatic test_startup();
    logic [63:0] lb, rb, el, er;
    apply_reset(1'b0);
    push_pair($urandom, $urandom);
    run_half(1'b0, 32, rb);
    n_cmp++; if (rb !== 64'd0) begin n_err++; $display("FAIL start_idle_out: got %h want 0", rb); end
    n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL start_no_pop: got %0d want 1", fifo_level); end
    n_cmp++; if (underrun_count !== 8'd0) begin n_err++; $display("FAIL start_underrun: got %0d want 0", underrun_count); end
    run_frame(32, lb, rb);
    model_frame(32, el, er);
    n_cmp++; if ({lb, rb} !== {el, er}) begin n_err++; $display("FAIL start_frame: got %h/%h want %h/%h", lb, rb, el, er); end
  endtask

  task automatic test_random_stream();
    logic [63:0] lb, rb, el, er;
    int          npush, nb;
    apply_reset(1'b0);
    for (int f = 0; f < 6; f++) begin
      npush = $urandom_range(0, 2);
      for (int p = 0; p < npush; p++) push_pair($urandom, $urandom);
      nb = ($urandom_range(0, 1) == 1) ? 36 : 32;
      run_frame(nb, lb, rb);
      model_frame(nb, el, er);
      n_cmp++; if ({lb, rb} !== {el, er}) begin n_err++; $display("FAIL rand_frame_%0d: got %h/%h want %h/%h", f, lb, rb, el, er); end
      n_cmp++; if (fifo_level !== 3'(mq.size())) begin n_err++; $display("FAIL rand_level_%0d: got %0d want %0d", f, fifo_level, mq.size()); end
      n_cmp++; if (underrun_count !== 8'(m_under)) begin n_err++; $display("FAIL rand_underrun_%0d: got %0d want %0d", f, underrun_count, m_under); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_full_fifo();
    test_underrun();
    test_simultaneous();
    test_mid_reset();
    test_startup();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
